// File: rtl/lcd_sequencer_pkg.sv
// Shared constants, command layout and FSM state type for the LCD nibble sequencer.
package lcd_pkg;

  localparam int unsigned CLK_FREQ       = 50_000_000;
  // 15 ms of power-up settling at CLK_FREQ
  localparam int unsigned POWERUP_CYCLES = CLK_FREQ / 1000 * 15;

  // Post-nibble waits in CLK cycles
  localparam logic [20:0] DLY_1US    = 21'd50;
  localparam logic [20:0] DLY_40US   = 21'd2000;
  localparam logic [20:0] DLY_100US  = 21'd5000;
  localparam logic [20:0] DLY_1640US = 21'd82000;
  localparam logic [20:0] DLY_4100US = 21'd205000;

  localparam logic [3:0] INIT_LAST = 4'd11;

  // command[4] = RS, command[3:0] = nibble
  typedef struct packed {
    logic       rs;
    logic [3:0] nibble;
  } cmd_t;

  typedef enum logic [2:0] {
    PWR_WAIT,
    ISSUE,
    WAIT_DONE,
    GAP,
    IDLE
  } state_t;

  // Clear display / return home (instruction 0x01..0x03) need the long wait.
  function automatic logic [20:0] low_nibble_delay(input logic rs, input logic [7:0] data);
    return (!rs && (data inside {8'h01, 8'h02, 8'h03})) ? DLY_1640US : DLY_40US;
  endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Host byte-write handshake into the LCD sequencer.
interface lcd_sequencer_if;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_sequencer_init_rom.sv
// Power-up init sequence: 12 instruction nibbles (RS=0) with their post-nibble waits.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [3:0]  index,
  output logic [3:0]  nibble,
  output logic [20:0] delay
);

  // Combinational lookup; indices past the last entry read as zero.
  always_comb begin
    nibble = '0;
    delay  = '0;
    case (index)
      4'd0:  begin nibble = 4'h3; delay = DLY_4100US; end
      4'd1:  begin nibble = 4'h3; delay = DLY_100US;  end
      4'd2:  begin nibble = 4'h3; delay = DLY_40US;   end
      4'd3:  begin nibble = 4'h2; delay = DLY_40US;   end
      4'd4:  begin nibble = 4'h2; delay = DLY_1US;    end
      4'd5:  begin nibble = 4'h8; delay = DLY_40US;   end
      4'd6:  begin nibble = 4'h0; delay = DLY_1US;    end
      4'd7:  begin nibble = 4'hC; delay = DLY_40US;   end
      4'd8:  begin nibble = 4'h0; delay = DLY_1US;    end
      4'd9:  begin nibble = 4'h1; delay = DLY_1640US; end
      4'd10: begin nibble = 4'h0; delay = DLY_1US;    end
      4'd11: begin nibble = 4'h6; delay = DLY_40US;   end
      default: begin nibble = '0; delay = '0; end
    endcase
  end

endmodule

// File: rtl/lcd_sequencer.sv
// Sequences LCD power-up init, then splits host bytes into two nibble transfers downstream.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned PWR_CYCLES = POWERUP_CYCLES
) (
  input  logic              CLK,
  input  logic              RESET,
  lcd_sequencer_if.slave    wr,
  output logic              init_done,
  output logic              sendCommand,
  output logic [4:0]        command,
  output logic [20:0]       commandDelay,
  input  logic              commandDone
);

  state_t      state;
  logic [19:0] pwr_cnt;
  logic [3:0]  rom_idx;
  logic        low_pending;
  logic        rs_q;
  logic [7:0]  data_q;

  logic [3:0]  rom_sel;
  logic [3:0]  rom_nibble;
  logic [20:0] rom_delay;

  // During GAP the ROM is already addressed at the next entry so ISSUE follows without a bubble.
  assign rom_sel = (state == GAP) ? rom_idx + 4'd1 : rom_idx;

  lcd_init_rom u_rom (
    .index  (rom_sel),
    .nibble (rom_nibble),
    .delay  (rom_delay)
  );

  // Main sequencer FSM; every output is registered and sendCommand is set on entry to ISSUE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= PWR_WAIT;
      pwr_cnt      <= '0;
      rom_idx      <= '0;
      low_pending  <= 1'b0;
      rs_q         <= 1'b0;
      data_q       <= '0;
      init_done    <= 1'b0;
      wr.wr_ready  <= 1'b0;
      sendCommand  <= 1'b0;
      command      <= '0;
      commandDelay <= '0;
    end else begin
      sendCommand <= 1'b0;
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == 20'(PWR_CYCLES - 1)) begin
            state        <= ISSUE;
            sendCommand  <= 1'b1;
            command      <= cmd_t'{rs: 1'b0, nibble: rom_nibble};
            commandDelay <= rom_delay;
          end else begin
            pwr_cnt <= pwr_cnt + 20'd1;
          end
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (commandDone) state <= GAP;
        end
        GAP: begin
          if (!init_done) begin
            if (rom_idx < INIT_LAST) begin
              rom_idx      <= rom_idx + 4'd1;
              state        <= ISSUE;
              sendCommand  <= 1'b1;
              command      <= cmd_t'{rs: 1'b0, nibble: rom_nibble};
              commandDelay <= rom_delay;
            end else begin
              init_done   <= 1'b1;
              wr.wr_ready <= 1'b1;
              state       <= IDLE;
            end
          end else if (low_pending) begin
            low_pending  <= 1'b0;
            state        <= ISSUE;
            sendCommand  <= 1'b1;
            command      <= cmd_t'{rs: rs_q, nibble: data_q[3:0]};
            commandDelay <= low_nibble_delay(rs_q, data_q);
          end else begin
            wr.wr_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        IDLE: begin
          if (wr.wr_valid && wr.wr_ready) begin
            rs_q         <= wr.wr_rs;
            data_q       <= wr.wr_data;
            low_pending  <= 1'b1;
            wr.wr_ready  <= 1'b0;
            state        <= ISSUE;
            sendCommand  <= 1'b1;
            command      <= cmd_t'{rs: wr.wr_rs, nibble: wr.wr_data[7:4]};
            commandDelay <= DLY_1US;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Randomized bench for lcd_sequencer against a queue-based model of the expected nibble stream.
module tb_lcd_sequencer;

  localparam int unsigned PWR = 200;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        init_done;
  logic        sendCommand;
  logic [4:0]  command;
  logic [20:0] commandDelay;
  logic        commandDone = 1'b0;

  lcd_sequencer_if wr_bus ();

  lcd_sequencer #(.PWR_CYCLES(PWR)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .wr           (wr_bus),
    .init_done    (init_done),
    .sendCommand  (sendCommand),
    .command      (command),
    .commandDelay (commandDelay),
    .commandDone  (commandDone)
  );

  always #10 CLK = ~CLK;

  typedef struct {
    logic [4:0]  cmd;
    logic [20:0] dly;
  } exp_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } wr_t;

  logic [3:0]  init_nib [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
  int unsigned init_dly [12] = '{205000, 5000, 2000, 2000, 50, 2000, 50, 2000, 50, 82000, 50, 2000};

  exp_t exp_q[$];
  wr_t  host_q[$];

  int cyc, next_send, done_at, send_cyc, last_done, idle_from, init_from, late_done;
  bit exp_rdy, exp_init, in_reset, hold, lat_rand;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic wr_t rand_write();
    wr_t w;
    w.rs = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) w.data = 8'($urandom_range(1, 3));
    else                           w.data = 8'($urandom);
    return w;
  endfunction

  // Model of an accepted byte: high nibble with 1 us, low nibble with 1.64 ms or 40 us.
  task automatic push_write(input wr_t w);
    exp_t e;
    e.cmd = {w.rs, w.data[7:4]};
    e.dly = 21'd50;
    exp_q.push_back(e);
    e.cmd = {w.rs, w.data[3:0]};
    e.dly = (w.rs == 1'b0 && w.data >= 8'd1 && w.data <= 8'd3) ? 21'd82000 : 21'd2000;
    exp_q.push_back(e);
  endtask

  task automatic release_reset(input int late);
    exp_t e;
    RESET = 1'b0;
    in_reset = 1'b0;
    cyc = 0;
    next_send = PWR;
    done_at = -1;
    send_cyc = -100;
    last_done = -100;
    idle_from = -1;
    init_from = -1;
    late_done = 0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      e.cmd = {1'b0, init_nib[i]};
      e.dly = 21'(init_dly[i]);
      exp_q.push_back(e);
    end
    if (late > 0) begin
      commandDone = 1'b1;
      late_done = late - 1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    in_reset = 1'b1;
    next_send = -1;
    done_at = -1;
    idle_from = -1;
    init_from = -1;
    late_done = 0;
    exp_q.delete();
    commandDone = 1'b0;
    wr_bus.wr_valid = 1'b0;
  endtask

  // One clock: check the cycle just begun against the model, then drive the inputs for it.
  task automatic step();
    exp_t e;
    wr_t  h;
    bit   cd;
    bit   v;
    @(posedge CLK);
    #1;
    cyc++;
    exp_rdy  = (idle_from >= 0 && cyc >= idle_from);
    exp_init = (init_from >= 0 && cyc >= init_from);

    check("sendCommand", sendCommand, 32'(cyc == next_send));
    if (sendCommand && cyc == next_send) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("command", command, e.cmd);
        check("commandDelay", commandDelay, e.dly);
      end
      next_send = -1;
      done_at = cyc + (lat_rand ? int'($urandom_range(1, 12)) : 10);
      send_cyc = cyc;
    end
    check("wr_ready", wr_bus.wr_ready, exp_rdy);
    check("init_done", init_done, exp_init);
    if (in_reset) begin
      check("reset_command", command, 0);
      check("reset_delay", commandDelay, 0);
    end

    cd = 1'b0;
    if (late_done > 0) begin
      cd = 1'b1;
      late_done--;
    end else if (!in_reset && done_at == cyc) begin
      cd = 1'b1;
      last_done = cyc;
      done_at = -1;
      if (exp_q.size() > 0) next_send = cyc + 2;
      else begin
        idle_from = cyc + 2;
        if (init_from < 0) init_from = cyc + 2;
      end
    end else if (!in_reset &&
                 ((exp_rdy && done_at < 0) || cyc == send_cyc || cyc == last_done + 1)) begin
      cd = ($urandom_range(0, 3) == 0);
    end
    commandDone = cd;

    if (in_reset) begin
      wr_bus.wr_valid = 1'b0;
    end else if (exp_rdy && host_q.size() > 0) begin
      h = host_q[0];
      v = hold || ($urandom_range(0, 1) == 1);
      wr_bus.wr_valid = v;
      wr_bus.wr_rs    = h.rs;
      wr_bus.wr_data  = h.data;
      if (v) begin
        void'(host_q.pop_front());
        push_write(h);
        next_send = cyc + 1;
        idle_from = -1;
      end
    end else begin
      wr_bus.wr_valid = exp_rdy ? 1'b0 : (hold || ($urandom_range(0, 1) == 1));
      wr_bus.wr_rs    = 1'($urandom_range(0, 1));
      wr_bus.wr_data  = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step();
      n++;
      ok = !in_reset && host_q.size() == 0 && next_send < 0 && done_at < 0 && exp_rdy;
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic wait_low_nibble(input int budget);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      step();
      n++;
      ok = host_q.size() == 0 && exp_q.size() == 0 && next_send < 0 && done_at >= 0;
    end
    check("low_nibble_reached", ok, 1);
  endtask

  initial begin
    wr_t w;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_rs    = 1'b0;
    wr_bus.wr_data  = '0;
    cyc = 0;
    next_send = -1;
    done_at = -1;
    send_cyc = -100;
    last_done = -100;
    idle_from = -1;
    init_from = -1;
    late_done = 0;
    in_reset = 1'b1;
    hold = 1'b0;
    lat_rand = 1'b0;

    repeat (4) step();
    release_reset(0);
    wait_idle(PWR + 1000);

    lat_rand = 1'b1;
    w.rs = 1'b1; w.data = 8'h41; host_q.push_back(w);
    wait_idle(200);
    w.rs = 1'b0; w.data = 8'h01; host_q.push_back(w);
    wait_idle(200);
    w.rs = 1'b1; w.data = 8'h01; host_q.push_back(w);
    wait_idle(200);

    hold = 1'b1;
    for (int i = 0; i < 8; i++) host_q.push_back(rand_write());
    wait_idle(1000);
    hold = 1'b0;

    for (int i = 0; i < 30; i++) host_q.push_back(rand_write());
    wait_idle(3000);

    // Reset while the low nibble of an instruction byte is waiting for commandDone.
    lat_rand = 1'b0;
    w.rs = 1'b0; w.data = 8'h02; host_q.push_back(w);
    wait_low_nibble(200);
    repeat (3) step();
    do_reset();
    repeat (2) step();
    release_reset(3);
    wait_idle(PWR + 1000);

    lat_rand = 1'b1;
    w.rs = 1'b0; w.data = 8'h03; host_q.push_back(w);
    w.rs = 1'b1; w.data = 8'hA5; host_q.push_back(w);
    wait_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
